fifo_wr_arbiter: RTL and testbench
==================================

FIFO_WR_ARBITER -- requirements
Module: fifo_wr_arbiter

Interface
REQ-001 SHALL have parameter FIFO_WIDTH, default 8, data width of each write beat.
REQ-002 SHALL have parameter NUM_REQ, default 4, number of requesters (2..8).
REQ-003 SHALL have parameter BURST_LEN, default 4, maximum beats per grant (1..16).
REQ-004 SHALL use one clock and an asynchronous, active-low reset.
REQ-005 clk  input  1  clock; all state updates on rising edge.
REQ-006 rstN  input  1  reset.
REQ-007 req_valid  input  NUM_REQ  per-requester beat valid.
REQ-008 req_data  input  NUM_REQ*FIFO_WIDTH  per-requester beat data; requester i occupies bits [i*FIFO_WIDTH +: FIFO_WIDTH].
REQ-009 req_ready  output  NUM_REQ  one-hot beat accept.
REQ-010 fifo_full  input  1  downstream FIFO full flag.
REQ-011 fifo_wr_en  output  1  write enable to the FIFO.
REQ-012 fifo_data_in  output  FIFO_WIDTH  write data to the FIFO.
REQ-013 grant_valid  output  1  a requester currently owns the FIFO.
REQ-014 grant_id  output  $clog2(NUM_REQ)  current owner index.

Function
REQ-015 SHALL implement FSM with states IDLE and BUSY.
REQ-016 IDLE: if any req_valid is high, SHALL select the first valid index at or after rr_ptr (wrapping modulo NUM_REQ), register it as owner, clear beat_cnt, and enter BUSY next cycle; otherwise remain IDLE.
REQ-017 Arbitration latency SHALL be exactly one cycle (IDLE cycle), giving one bubble between bursts.
REQ-018 BUSY: req_ready[owner] = req_valid[owner] & ~fifo_full, combinational; all other req_ready bits SHALL be 0.
REQ-019 BUSY: fifo_wr_en SHALL equal req_ready[owner]; fifo_data_in SHALL equal req_data slice of owner.
REQ-020 An accepted beat (fifo_wr_en=1) SHALL increment beat_cnt; a stalled beat (fifo_full=1) SHALL neither increment beat_cnt nor release the grant.
REQ-021 BUSY SHALL exit to IDLE when an accepted beat brings beat_cnt to BURST_LEN, or when req_valid[owner]=0 in a cycle; on exit rr_ptr SHALL become (owner+1) mod NUM_REQ.
REQ-022 fifo_full asserted throughout a burst SHALL hold BUSY indefinitely (no timeout).
REQ-023 A requester dropping valid mid-burst SHALL forfeit the rest of its burst; no beat is written that cycle.
REQ-024 In IDLE, fifo_wr_en and all req_ready SHALL be 0 and fifo_data_in SHALL be 0.
REQ-025 grant_valid SHALL be 1 exactly in BUSY; grant_id SHALL show owner in BUSY and 0 in IDLE.
REQ-026 At most one fifo_wr_en per cycle; no beat SHALL ever be written while fifo_full=1.
REQ-027 beat_cnt SHALL be $clog2(BURST_LEN+1) bits wide and never wrap.

Reset
REQ-028 On rstN low, asynchronously: state=IDLE, rr_ptr=0, owner=0, beat_cnt=0; all outputs 0.
REQ-029 Reset mid-burst SHALL abandon the burst with no further writes; after release, arbitration restarts from index 0.

Structure
REQ-030 Package fifo_arb_pkg SHALL hold the state enum (IDLE, BUSY) and constants DEF_NUM_REQ=4, DEF_BURST_LEN=4.
REQ-031 Round-robin selection SHALL be a sub-module rr_pick (inputs: request vector, pointer; outputs: found, index), purely combinational.

Verification
REQ-032 Only req 2 valid with 6 beats, fifo_full=0 -> grant 2 after 1 cycle, 4 writes back-to-back, 1 IDLE bubble, then remaining 2 writes.
REQ-033 All 4 reqs continuously valid from reset -> grant order 0,1,2,3,0, each 4 beats, 4-beat bursts separated by single bubbles.
REQ-034 Req 1 in BUSY, fifo_full high for 3 cycles after beat 2 -> no fifo_wr_en and req_ready=0 for those 3 cycles, burst resumes, total 4 beats.
REQ-035 Req 0 drops valid after beat 1, req 3 valid -> return to IDLE, rr_ptr=1, next grant 3.
REQ-036 rstN pulsed low during beat 2 of req 2 -> outputs 0 immediately, next grant goes to lowest valid index from 0.
REQ-037 Scoreboard: FIFO write stream per requester equals that requester's accepted beats in order, with no write while fifo_full=1.

Source files
------------

// File: rtl/fifo_arb_pkg.sv
// Shared types and defaults for the round-robin FIFO write arbiter.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } arb_state_e;

    localparam int DEF_NUM_REQ   = 4;
    localparam int DEF_BURST_LEN = 4;

endpackage

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping.
module rr_pick #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          found,
    output logic [IW-1:0] index
);

    logic [2*N-1:0] dbl;
    logic [N-1:0]   rot;
    logic [IW:0]    sum;

    // Rotate so bit k of rot is request (ptr + k) mod N; scan from the top so the lowest k wins.
    always_comb begin
        dbl   = {req, req} >> ptr;
        rot   = dbl[N-1:0];
        found = 1'b0;
        index = '0;
        sum   = '0;
        for (int k = N - 1; k >= 0; k--) begin
            if (rot[k]) begin
                found = 1'b1;
                sum   = {1'b0, ptr} + (IW+1)'(k);
                if (sum >= (IW+1)'(N)) begin
                    sum = sum - (IW+1)'(N);
                end
                index = sum[IW-1:0];
            end
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Grants one requester at a time bounded write bursts into a FIFO, round-robin,
// with a one-cycle arbitration bubble between bursts.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int FIFO_WIDTH = 8,
    parameter int NUM_REQ    = DEF_NUM_REQ,
    parameter int BURST_LEN  = DEF_BURST_LEN
) (
    input  logic                          clk,
    input  logic                          rstN,
    input  logic [NUM_REQ-1:0]            req_valid,
    input  logic [NUM_REQ*FIFO_WIDTH-1:0] req_data,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic                          fifo_full,
    output logic                          fifo_wr_en,
    output logic [FIFO_WIDTH-1:0]         fifo_data_in,
    output logic                          grant_valid,
    output logic [$clog2(NUM_REQ)-1:0]    grant_id
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(BURST_LEN + 1);

    arb_state_e       state_q, state_d;
    logic [ID_W-1:0]  owner_q, owner_d;
    logic [ID_W-1:0]  rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;

    logic                  pick_found;
    logic [ID_W-1:0]       pick_idx;
    logic                  owner_valid;
    logic [FIFO_WIDTH-1:0] owner_data;
    logic                  accept;
    logic [ID_W-1:0]       next_ptr;

    rr_pick #(
        .N  (NUM_REQ),
        .IW (ID_W)
    ) u_rr_pick (
        .req   (req_valid),
        .ptr   (rr_ptr_q),
        .found (pick_found),
        .index (pick_idx)
    );

    always_comb begin
        owner_valid = 1'b0;
        owner_data  = '0;
        for (int i = 0; i < NUM_REQ; i++) begin
            if (owner_q == ID_W'(i)) begin
                owner_valid = req_valid[i];
                owner_data  = req_data[i*FIFO_WIDTH +: FIFO_WIDTH];
            end
        end
    end

    assign next_ptr = (owner_q == ID_W'(NUM_REQ - 1)) ? '0 : owner_q + ID_W'(1);

    // A stalled beat keeps both the grant and the count; a dropped valid ends the burst.
    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        beat_cnt_d   = beat_cnt_q;
        rr_ptr_d     = rr_ptr_q;
        accept       = 1'b0;
        req_ready    = '0;
        fifo_wr_en   = 1'b0;
        fifo_data_in = '0;
        grant_valid  = 1'b0;
        grant_id     = '0;
        case (state_q)
            IDLE: begin
                if (pick_found) begin
                    state_d    = BUSY;
                    owner_d    = pick_idx;
                    beat_cnt_d = '0;
                end
            end
            BUSY: begin
                accept       = owner_valid && !fifo_full;
                grant_valid  = 1'b1;
                grant_id     = owner_q;
                fifo_wr_en   = accept;
                fifo_data_in = owner_data;
                for (int i = 0; i < NUM_REQ; i++) begin
                    req_ready[i] = accept && (owner_q == ID_W'(i));
                end
                if (accept) begin
                    beat_cnt_d = beat_cnt_q + CNT_W'(1);
                end
                if ((accept && beat_cnt_q == CNT_W'(BURST_LEN - 1)) || !owner_valid) begin
                    state_d  = IDLE;
                    rr_ptr_d = next_ptr;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q    <= IDLE;
            owner_q    <= '0;
            rr_ptr_q   <= '0;
            beat_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            owner_q    <= owner_d;
            rr_ptr_q   <= rr_ptr_d;
            beat_cnt_q <= beat_cnt_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench: vector table, directed corner sequences, and randomized
// traffic against a behavioural arbiter model with a per-requester write scoreboard.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int W  = 8;
    localparam int BL = 4;

    logic            clk;
    logic            rstN;
    logic [NR-1:0]   req_valid;
    logic [NR*W-1:0] req_data;
    logic [NR-1:0]   req_ready;
    logic            fifo_full;
    logic            fifo_wr_en;
    logic [W-1:0]    fifo_data_in;
    logic            grant_valid;
    logic [1:0]      grant_id;

    int testsRun    = 0;
    int testsFailed = 0;

    typedef struct {
        logic       rst;
        logic [3:0] valid;
        logic       full;
        logic       expWr;
        logic [3:0] expReady;
        logic       expGv;
        logic [1:0] expGid;
    } vec_t;

    vec_t vecs[$];

    fifo_wr_arbiter #(
        .FIFO_WIDTH (W),
        .NUM_REQ    (NR),
        .BURST_LEN  (BL)
    ) dut (
        .clk          (clk),
        .rstN         (rstN),
        .req_valid    (req_valid),
        .req_data     (req_data),
        .req_ready    (req_ready),
        .fifo_full    (fifo_full),
        .fifo_wr_en   (fifo_wr_en),
        .fifo_data_in (fifo_data_in),
        .grant_valid  (grant_valid),
        .grant_id     (grant_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic vec_t mk(logic rst, logic [3:0] valid, logic full, logic expWr,
                                logic [3:0] expReady, logic expGv, logic [1:0] expGid);
        vec_t v;
        v.rst = rst; v.valid = valid; v.full = full; v.expWr = expWr;
        v.expReady = expReady; v.expGv = expGv; v.expGid = expGid;
        return v;
    endfunction

    function automatic logic [7:0] fixedData(logic gv, logic [1:0] gid);
        return gv ? (8'hA0 + {6'd0, gid}) : 8'h00;
    endfunction

    task automatic setFixedData();
        for (int i = 0; i < NR; i++) req_data[i*W +: W] = 8'hA0 + 8'(i);
    endtask

    task automatic applyStimulus(input logic rst, input logic [3:0] valid, input logic full);
        @(negedge clk);
        rstN      = rst;
        req_valid = valid;
        fifo_full = full;
        #1;
    endtask

    task automatic checkOutput(input string name, input logic expWr, input logic [3:0] expReady,
                               input logic expGv, input logic [1:0] expGid, input logic [7:0] expData);
        testsRun++;
        if (fifo_wr_en !== expWr || req_ready !== expReady || grant_valid !== expGv ||
            grant_id !== expGid || fifo_data_in !== expData) begin
            testsFailed++;
            $display("[TB] FAIL %s: got wr=%b rdy=%b gv=%b gid=%0d data=%h, expected wr=%b rdy=%b gv=%b gid=%0d data=%h",
                     name, fifo_wr_en, req_ready, grant_valid, grant_id, fifo_data_in,
                     expWr, expReady, expGv, expGid, expData);
        end
    endtask

    task automatic runStep(input string name, input logic rst, input logic [3:0] valid, input logic full,
                           input logic expWr, input logic [3:0] expReady, input logic expGv,
                           input logic [1:0] expGid);
        applyStimulus(rst, valid, full);
        checkOutput(name, expWr, expReady, expGv, expGid, fixedData(expGv, expGid));
    endtask

    // Behavioural model state for the randomized phase
    bit        mBusy;
    int        mOwner, mCnt, mPtr;
    int        seq[NR];
    int        seqExp[NR];
    logic [NR-1:0] readySeen;

    initial begin
        rstN      = 1'b0;
        req_valid = '0;
        fifo_full = 1'b0;
        req_data  = '0;
        setFixedData();

        // Single requester 2 with six beats, then a stalled burst from requester 1
        vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 4'b0100, 0, 0, 4'b0000, 0, 0));
        for (int b = 0; b < 4; b++) vecs.push_back(mk(1, 4'b0100, 0, 1, 4'b0100, 1, 2));
        vecs.push_back(mk(1, 4'b0100, 0, 0, 4'b0000, 0, 0));
        for (int b = 0; b < 2; b++) vecs.push_back(mk(1, 4'b0100, 0, 1, 4'b0100, 1, 2));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 1, 2));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0));
        vecs.push_back(mk(0, 4'b0000, 0, 0, 4'b0000, 0, 0));
        vecs.push_back(mk(1, 4'b0010, 0, 0, 4'b0000, 0, 0));
        for (int b = 0; b < 2; b++) vecs.push_back(mk(1, 4'b0010, 0, 1, 4'b0010, 1, 1));
        for (int b = 0; b < 3; b++) vecs.push_back(mk(1, 4'b0010, 1, 0, 4'b0000, 1, 1));
        for (int b = 0; b < 2; b++) vecs.push_back(mk(1, 4'b0010, 0, 1, 4'b0010, 1, 1));
        vecs.push_back(mk(1, 4'b0000, 0, 0, 4'b0000, 0, 0));

        for (int i = 0; i < vecs.size(); i++) begin
            runStep($sformatf("table[%0d]", i), vecs[i].rst, vecs[i].valid, vecs[i].full,
                    vecs[i].expWr, vecs[i].expReady, vecs[i].expGv, vecs[i].expGid);
        end

        // All requesters continuously valid: grants rotate 0,1,2,3,0 with a bubble each
        runStep("rr reset", 0, 4'hF, 0, 0, 4'b0000, 0, 0);
        for (int g = 0; g < 5; g++) begin
            runStep($sformatf("rr bubble %0d", g), 1, 4'hF, 0, 0, 4'b0000, 0, 0);
            for (int b = 0; b < 4; b++) begin
                runStep($sformatf("rr grant %0d beat %0d", g, b), 1, 4'hF, 0,
                        1, 4'(1 << (g % 4)), 1, 2'(g % 4));
            end
        end

        // Requester 0 forfeits after one beat; pointer moves past it to requester 3
        runStep("drop reset", 0, 4'b1001, 0, 0, 4'b0000, 0, 0);
        runStep("drop idle", 1, 4'b1001, 0, 0, 4'b0000, 0, 0);
        runStep("drop beat1", 1, 4'b1001, 0, 1, 4'b0001, 1, 0);
        runStep("drop forfeit", 1, 4'b1000, 0, 0, 4'b0000, 1, 0);
        runStep("drop bubble", 1, 4'b1001, 0, 0, 4'b0000, 0, 0);
        runStep("drop next grant", 1, 4'b1001, 0, 1, 4'b1000, 1, 3);

        // Reset in the middle of requester 2's burst restarts arbitration at index 0
        runStep("mid reset init", 0, 4'b0010, 0, 0, 4'b0000, 0, 0);
        runStep("mid idle", 1, 4'b0010, 0, 0, 4'b0000, 0, 0);
        for (int b = 0; b < 4; b++) runStep("mid req1 burst", 1, 4'b0010, 0, 1, 4'b0010, 1, 1);
        runStep("mid bubble", 1, 4'b0100, 0, 0, 4'b0000, 0, 0);
        runStep("mid req2 beat1", 1, 4'b0100, 0, 1, 4'b0100, 1, 2);
        runStep("mid async reset", 0, 4'b0100, 0, 0, 4'b0000, 0, 0);
        runStep("mid post idle", 1, 4'b0101, 0, 0, 4'b0000, 0, 0);
        runStep("mid post grant", 1, 4'b0101, 0, 1, 4'b0001, 1, 0);

        // Randomized traffic against the model
        applyStimulus(0, 4'b0000, 0);
        mBusy = 0; mOwner = 0; mCnt = 0; mPtr = 0;
        readySeen = '0;
        for (int i = 0; i < NR; i++) begin
            seq[i] = 0;
            seqExp[i] = 0;
        end
        for (int c = 0; c < 2000; c++) begin
            logic       acc;
            logic [3:0] expReady;
            logic [7:0] expData;
            logic [3:0] id;
            bit         found;
            @(negedge clk);
            for (int i = 0; i < NR; i++) begin
                if (readySeen[i]) seq[i]++;
                if ($urandom_range(0, 99) < 15) req_valid[i] = ~req_valid[i];
                req_data[i*W +: W] = {4'(i), 4'(seq[i])};
            end
            fifo_full = ($urandom_range(0, 99) < 20);
            rstN = 1'b1;
            #1;

            acc      = mBusy && req_valid[mOwner] && !fifo_full;
            expReady = acc ? 4'(1 << mOwner) : 4'b0000;
            expData  = mBusy ? req_data[mOwner*W +: W] : 8'h00;
            checkOutput($sformatf("random cycle %0d", c), acc, expReady, mBusy,
                        mBusy ? 2'(mOwner) : 2'd0, expData);
            readySeen = req_ready;

            if (fifo_wr_en) begin
                testsRun++;
                id = fifo_data_in[7:4];
                if (fifo_full || id >= 4'(NR) || fifo_data_in[3:0] != 4'(seqExp[id])) begin
                    testsFailed++;
                    $display("[TB] FAIL scoreboard cycle %0d: got data=%h full=%b, expected seq=%0d with full=0",
                             c, fifo_data_in, fifo_full, (id < 4'(NR)) ? seqExp[id] : -1);
                end else begin
                    seqExp[id]++;
                end
            end

            if (!mBusy) begin
                found = 0;
                for (int k = 0; k < NR; k++) begin
                    if (!found && req_valid[(mPtr + k) % NR]) begin
                        found  = 1;
                        mBusy  = 1;
                        mOwner = (mPtr + k) % NR;
                        mCnt   = 0;
                    end
                end
            end else begin
                if (acc) mCnt++;
                if (mCnt == BL || !req_valid[mOwner]) begin
                    mBusy = 0;
                    mPtr  = (mOwner + 1) % NR;
                end
            end
        end

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule
